// File: rtl/fetch_unit_param.sv
// ============================================================================
// Module : fetch_unit_param
// Brief  : Parametrised fetch-stage PC sequencer with a bounded return stack.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit_param #(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               jump,
  input  logic                               branch_taken,
  input  logic [PC_W-1:0]                    target_addr,
  input  logic [PC_W-1:0]                    branch_offset,
  output logic [PC_W-1:0]                    pc,
  output logic [PC_W-1:0]                    return_address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [PC_W-1:0]  c_pc_one  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STACK_DEPTH);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_stack [STACK_DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_top_idx;
  logic [PC_W-1:0]  w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  // Push slot is only used when not full, so count always fits the index width.
  assign w_cnt_dec  = r_count - c_cnt_one;
  assign w_push_idx = r_count[IDX_W-1:0];
  assign w_top_idx  = w_cnt_dec[IDX_W-1:0];
  assign w_top      = r_stack[w_top_idx];
  assign w_full     = (r_count == c_cnt_max);
  assign w_empty    = (r_count == '0);
  assign w_pc_inc   = r_pc + c_pc_one;

  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_cnt_nxt = r_count;
    w_push    = 1'b0;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    if (stall) begin
      w_pc_nxt = r_pc;
    end else if (call) begin
      if (w_full) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_cnt_nxt = r_count + c_cnt_one;
        w_pc_nxt  = target_addr;
      end
    end else if (ret) begin
      if (w_empty) begin
        w_unf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = w_cnt_dec;
        w_pc_nxt  = w_top;
      end
    end else if (jump) begin
      w_pc_nxt = target_addr;
    end else if (branch_taken) begin
      // Two's-complement add truncated to PC_W wraps in both directions.
      w_pc_nxt = r_pc + branch_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_count     <= w_cnt_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_unf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc              = r_pc;
  assign return_address  = w_empty ? '0 : w_top;
  assign stack_count     = r_count;
  assign stack_full      = w_full;
  assign stack_empty     = w_empty;
  assign stack_overflow  = r_overflow;
  assign stack_underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit_param.sv
// ============================================================================
// Module : tb_fetch_unit_param
// Brief  : Self-checking bench for fetch_unit_param (PC_W=8, STACK_DEPTH=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit_param;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset, stall, call, ret, jump, branch_taken;
  logic [PC_W-1:0]  target_addr, branch_offset;
  logic [PC_W-1:0]  pc, return_address;
  logic [2:0]       stack_count;
  logic             stack_full, stack_empty, stack_overflow, stack_underflow;

  fetch_unit_param #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .call(call), .ret(ret),
    .jump(jump), .branch_taken(branch_taken), .target_addr(target_addr),
    .branch_offset(branch_offset), .pc(pc), .return_address(return_address),
    .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pc as an integer, return stack as a queue.
  int m_pc;
  int m_stk[$];
  int m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int o;
    if (reset) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = 0; m_unf = 0;
      if (stall) begin
      end else if (call) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % 256);
          m_pc = int'(target_addr);
        end else begin
          m_pc = (m_pc + 1) % 256; m_ovf = 1;
        end
      end else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % 256; m_unf = 1; end
      end else if (jump) begin
        m_pc = int'(target_addr);
      end else if (branch_taken) begin
        o = (branch_offset >= 8'd128) ? int'(branch_offset) - 256 : int'(branch_offset);
        m_pc = (m_pc + o + 256) % 256;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic check_model();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("return_address", 32'(return_address), (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'd0);
    chk("stack_count", 32'(stack_count), 32'(m_stk.size()));
    chk("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
    chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
    chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic r, s, c, rt, j, b, input logic [7:0] tgt, off);
    reset = r; stall = s; call = c; ret = rt; jump = j; branch_taken = b;
    target_addr = tgt; branch_offset = off;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  typedef struct {
    logic       rst, stl, cal, rt, jmp, br;
    logic [7:0] tgt, off;
    logic [7:0] e_pc, e_ra;
    logic [2:0] e_cnt;
    logic       e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, stl, cal, rt, jmp, br,
                              input logic [7:0] tgt, off, e_pc, e_ra,
                              input logic [2:0] e_cnt, input logic e_ovf, e_unf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.cal = cal; v.rt = rt; v.jmp = jmp; v.br = br;
    v.tgt = tgt; v.off = off; v.e_pc = e_pc; v.e_ra = e_ra;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  initial begin
    //                rst stl cal ret jmp br  tgt    off    pc     ra     cnt ovf unf
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 3'd0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'hFE, 8'hFF, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h03, 8'h02, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h03, 8'h00, 3'd0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 3'd0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h05, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h05, 8'h00, 8'h05, 8'h06, 3'd1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h06, 8'h00, 8'h06, 8'h06, 3'd2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h07, 8'h06, 3'd2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 8'h60, 8'h00, 8'h60, 8'h08, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 8'h60, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h30, 8'h00, 8'h30, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h99, 8'h05, 8'h30, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h99, 8'h05, 8'h30, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h99, 8'h05, 8'h30, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h30, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h55, 8'h00, 8'h55, 8'h00, 3'd0, 0, 0));

    // Reset and idle count with wrap.
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("reset_pc", 32'(pc), 32'h00);
    chk("reset_count", 32'(stack_count), 32'd0);
    idle(260);
    chk("idle_wrap_pc", 32'(pc), 32'h04);
    chk("idle_empty", 32'(stack_empty), 32'd1);

    // Nested call / return.
    idle(12);
    chk("seq2_pc10", 32'(pc), 32'h10);
    cyc(0, 0, 1, 0, 0, 0, 8'h40, 8'h00);
    chk("call1_pc", 32'(pc), 32'h40);
    chk("call1_ra", 32'(return_address), 32'h11);
    chk("call1_cnt", 32'(stack_count), 32'd1);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0, 8'h80, 8'h00);
    chk("call2_pc", 32'(pc), 32'h80);
    chk("call2_ra", 32'(return_address), 32'h43);
    chk("call2_cnt", 32'(stack_count), 32'd2);
    idle(1);
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    chk("ret1_pc", 32'(pc), 32'h43);
    chk("ret1_cnt", 32'(stack_count), 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    chk("ret2_pc", 32'(pc), 32'h11);
    chk("ret2_cnt", 32'(stack_count), 32'd0);

    // Fill the stack, then back-to-back overflow.
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(5);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 8'h20, 8'h00);
    chk("fill_cnt", 32'(stack_count), 32'd4);
    chk("fill_full", 32'(stack_full), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 8'h20, 8'h00);
    chk("ovf_pc", 32'(pc), 32'h21);
    chk("ovf_pulse", 32'(stack_overflow), 32'd1);
    chk("ovf_cnt", 32'(stack_count), 32'd4);
    cyc(0, 0, 1, 0, 0, 0, 8'h20, 8'h00);
    chk("ovf2_pc", 32'(pc), 32'h22);
    chk("ovf2_pulse", 32'(stack_overflow), 32'd1);
    idle(1);
    chk("ovf_clear", 32'(stack_overflow), 32'd0);

    // Table-driven corner cases.
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].stl, tbl[i].cal, tbl[i].rt, tbl[i].jmp, tbl[i].br,
          tbl[i].tgt, tbl[i].off);
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_ra", i), 32'(return_address), 32'(tbl[i].e_ra));
      chk($sformatf("tbl%0d_cnt", i), 32'(stack_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(stack_overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_unf", i), 32'(stack_underflow), 32'(tbl[i].e_unf));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit_param.md
Name: fetch_unit_param

Overview:
Parametrised program-counter sequencer for the core's fetch stage. It generalises the 4-bit fetch unit to a configurable PC width and a configurable return-stack depth. It adds stall, signed branch offsets, bounded stack occupancy with full/empty flags, and overflow/underflow error reporting. It drives the instruction-memory address and receives control decodes from the decode stage.

Parameters:
PC_W, 8, width of pc, target and offset buses (≥2)
STACK_DEPTH, 8, number of return-address entries (≥2)
RESET_PC, 0, pc value loaded on reset (PC_W bits)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
stall  input  1  hold all state this cycle
call  input  1  push pc+1, load target_addr
ret  input  1  pop top of stack into pc
jump  input  1  load target_addr
branch_taken  input  1  pc <= pc + branch_offset
target_addr  input  PC_W  absolute destination for call/jump
branch_offset  input  PC_W  two's-complement signed offset
pc  output  PC_W  current fetch address (registered)
return_address  output  PC_W  top-of-stack value; 0 when empty
stack_count  output  $clog2(STACK_DEPTH+1)  occupied entries
stack_full  output  1  stack_count == STACK_DEPTH
stack_empty  output  1  stack_count == 0
stack_overflow  output  1  one-cycle pulse: call attempted while full
stack_underflow  output  1  one-cycle pulse: ret attempted while empty

Behaviour:
- Interface: one clock clk; reset is synchronous, active-high, and sampled only on the rising edge of clk.
- Reset: pc=RESET_PC, stack_count=0, stack_overflow=0, stack_underflow=0. Stack RAM contents are don't-care and need not be cleared. Reset overrides every other input in the same cycle.
- Priority per cycle: reset > stall > call > ret > jump > branch_taken > sequential. Lower-priority requests asserted simultaneously are ignored, not queued.
- stall=1:
  - pc, stack and stack_count hold.
  - Both error pulses are 0.
  - All control inputs are ignored.
- call:
  - If not full: stack[stack_count] <= pc+1 (mod 2^PC_W), stack_count+1, pc <= target_addr.
  - If full: stack unchanged, pc <= pc+1, stack_overflow=1 for the next cycle.
- ret:
  - If not empty: pc <= stack[stack_count-1], stack_count-1.
  - If empty: pc <= pc+1, stack_underflow=1 for the next cycle.
- jump: pc <= target_addr.
- branch_taken:
  - pc <= pc + branch_offset, with branch_offset treated as signed.
  - Result truncated to PC_W bits, i.e. wraps modulo 2^PC_W in both directions.
- Sequential: pc <= pc+1. Wraps from 2^PC_W-1 to 0.
- Latency: all pc updates are visible one cycle after the edge that samples the control inputs. No combinational path from inputs to pc.
- Combinational outputs from registered state:
  - return_address = stack[stack_count-1] when not empty, else 0.
  - stack_full and stack_empty are decoded directly from stack_count.
- Error pulses:
  - Registered and high for exactly one cycle per offending request.
  - Back-to-back offending requests give back-to-back pulses.
- call and ret in the same cycle: call wins per priority, and the ret is discarded.
- Return address pushed at pc=2^PC_W-1 is 0 (wrapped).
- stack_count never exceeds STACK_DEPTH and never underflows below 0.

Test Plan:
(PC_W=8, STACK_DEPTH=4, RESET_PC=0)
1. Reset, then 260 idle cycles -> pc counts 0..255, wraps to 0 then continues to 4; stack_empty=1 throughout.
2. At pc=0x10 call target 0x40; at pc=0x42 call target 0x80; at pc=0x81 ret; then ret ->
   - pc=0x40, return_address=0x11, count=1;
   - pc=0x80, return_address=0x43, count=2;
   - pc=0x43, count=1;
   - pc=0x11, count=0.
3. Five consecutive calls to 0x20 starting at pc=0x05 ->
   - first four push, count=4, stack_full=1;
   - fifth gives pc=0x21, stack_overflow pulses one cycle, count stays 4.
4. From reset, ret at pc=0x00 -> pc=0x01, stack_underflow=1 for one cycle, count=0. Then branch_taken offset 0xFE at pc=0x01 -> pc=0xFF. Then branch offset 0x03 -> pc=0x02.
5. At pc=0x30 assert stall with call, jump and branch_taken for 3 cycles -> pc=0x30, count unchanged, no error pulses. Release stall with jump to 0x55 -> pc=0x55.
6. call+ret+jump together at pc=0x07 with count=2, target 0x60 -> pc=0x60, count=3, return_address=0x08. Assert reset with call the next cycle -> pc=0x00, count=0, no pulses.
